// File: rtl/avalon_pkg.sv
// Shared types and helpers for the Avalon-MM memory slave.
package avalon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } avmem_state_t;

    localparam int BYTE_LANES = 4;

    // Replaces only the byte lanes selected by be; all other lanes keep old_word.
    function automatic logic [31:0] lane_merge(input logic [31:0]           old_word,
                                               input logic [31:0]           new_word,
                                               input logic [BYTE_LANES-1:0] be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/avalon_wait_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying 0..3 extra wait cycles;
// used only when AVMEM_RANDOM_WAIT_EN is defined.
module avalon_wait_lfsr (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [1:0] extra_wait
);

    logic [15:0] lfsr;
    logic        feedback;

    assign feedback   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign extra_wait = lfsr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else if (advance) begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule

// File: rtl/avalon_mem_slave.sv
// Word-addressed RAM behind an Avalon-MM slave port with programmable wait states.
// Define AVMEM_RANDOM_WAIT_EN to add 0..3 pseudo-random extra wait cycles per transaction.
module avalon_mem_slave
    import avalon_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int          WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           av_address,
    input  logic                  av_read,
    input  logic                  av_write,
    input  logic [31:0]           av_writedata,
    input  logic [BYTE_LANES-1:0] av_byteenable,
    output logic                  av_waitrequest,
    output logic [31:0]           av_readdata,
    output logic                  err_oob,
    output logic                  err_proto
);

    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    logic [31:0]      mem [DEPTH_WORDS];
    avmem_state_t     state;
    logic [4:0]       count;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic [1:0]       extra_wait;
    logic [4:0]       total_wait;
    logic             one_req;
    logic             both_req;
    logic             no_req;

    // Unsigned wrap makes addresses below BASE_ADDR land far above SPAN.
    assign offset   = av_address - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign idx      = offset[IDX_W+1:2];
    assign rd_word  = in_range ? mem[idx] : 32'd0;

    assign one_req  = av_read ^ av_write;
    assign both_req = av_read & av_write;
    assign no_req   = ~(av_read | av_write);

`ifdef AVMEM_RANDOM_WAIT_EN
    avalon_wait_lfsr u_wait_lfsr (
        .clk        (clk),
        .reset      (reset),
        .advance    (state == ACK),
        .extra_wait (extra_wait)
    );
`else
    assign extra_wait = 2'd0;
`endif

    assign total_wait = 5'(WAIT_CYCLES) + {3'd0, extra_wait};

    always_comb begin
        av_waitrequest = 1'b0;
        unique case (state)
            IDLE:    av_waitrequest = one_req;
            WAIT:    av_waitrequest = 1'b1;
            default: av_waitrequest = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= 5'd0;
            av_readdata <= 32'd0;
            err_oob     <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            err_oob   <= 1'b0;
            err_proto <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (both_req) begin
                        err_proto <= 1'b1;
                    end else if (one_req) begin
                        count       <= 5'd1;
                        av_readdata <= rd_word;
                        state       <= (total_wait == 5'd1) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (no_req) begin
                        state <= IDLE;
                    end else begin
                        count       <= count + 5'd1;
                        av_readdata <= rd_word;
                        if (count == total_wait - 5'd1) state <= ACK;
                    end
                end
                ACK: begin
                    err_oob <= ~in_range;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; contents must survive reset and a reset
    // branch would prevent mapping it onto block memory.
    always_ff @(posedge clk) begin
        if (state == ACK && av_write && in_range) begin
            mem[idx] <= lane_merge(mem[idx], av_writedata, av_byteenable);
        end
    end

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Directed, table-driven bench for avalon_mem_slave with hand sequences for
// reset, protocol error, abort and back-to-back corner cases.
module tb_avalon_mem_slave;

    localparam logic [31:0] BASE = 32'hBFC0_0000;
    localparam int          WC   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        err_oob;
    logic        err_proto;

    int tests  = 0;
    int failed = 0;

    logic [15:0] lfsr_model;

    avalon_mem_slave #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WC),
        .INIT_FILE   ("")
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_write       (av_write),
        .av_writedata   (av_writedata),
        .av_byteenable  (av_byteenable),
        .av_waitrequest (av_waitrequest),
        .av_readdata    (av_readdata),
        .err_oob        (err_oob),
        .err_proto      (err_proto)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        check_rd;
        logic [31:0] exp_rd;
        logic        exp_oob;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    // Reference wait window: WAIT_CYCLES plus the model LFSR's low bits when enabled.
    function automatic int exp_window();
`ifdef AVMEM_RANDOM_WAIT_EN
        return WC + int'(lfsr_model[1:0]);
`else
        return WC;
`endif
    endfunction

    task automatic model_advance();
        lfsr_model = {lfsr_model[14:0], lfsr_model[15] ^ lfsr_model[13] ^ lfsr_model[12] ^ lfsr_model[10]};
    endtask

    // Counts waitrequest-high cycles of the current request until the low cycle.
    task automatic count_window(output int waits, output logic [31:0] rdata);
        waits = 0;
        #1;
        while (av_waitrequest && waits < 40) begin
            waits++;
            @(negedge clk);
            #1;
        end
        rdata = av_readdata;
    endtask

    task automatic xfer(input logic is_write, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, output int waits, output logic [31:0] rdata,
                        output logic oob_pulse, output logic oob_after);
        @(negedge clk);
        av_write      = is_write;
        av_read       = ~is_write;
        av_address    = addr;
        av_writedata  = data;
        av_byteenable = be;
        count_window(waits, rdata);
        @(negedge clk);
        av_read   = 1'b0;
        av_write  = 1'b0;
        oob_pulse = err_oob;
        @(negedge clk);
        oob_after = err_oob;
        model_advance();
    endtask

    initial begin
        int          waits;
        int          w0;
        int          w1;
        logic [31:0] rdata;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        oob_pulse;
        logic        oob_after;
        int          ew;

        vecs[0]  = '{1'b1, BASE + 32'h8,    32'hDEADBEEF, 4'hF, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, BASE + 32'h8,    32'h0,        4'h0, 1'b1, 32'hDEADBEEF,  1'b0};
        vecs[2]  = '{1'b1, BASE,            32'h11223344, 4'hF, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, BASE,            32'hAA000000, 4'h8, 1'b0, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, BASE,            32'h0,        4'h0, 1'b1, 32'hAA223344,  1'b0};
        vecs[5]  = '{1'b1, BASE + 32'h4,    32'h01020304, 4'hF, 1'b0, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, BASE + 32'h4,    32'h55667788, 4'h0, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, BASE + 32'h4,    32'h0,        4'h0, 1'b1, 32'h01020304,  1'b0};
        vecs[8]  = '{1'b1, BASE + 32'h4,    32'hA1B2C3D4, 4'h5, 1'b0, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, BASE + 32'h4,    32'h0,        4'h0, 1'b1, 32'h01B203D4,  1'b0};
        vecs[10] = '{1'b0, BASE - 32'h4,    32'h0,        4'h0, 1'b1, 32'h0,         1'b1};
        vecs[11] = '{1'b1, BASE + 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,         1'b1};
        vecs[12] = '{1'b1, BASE + 32'hFFC,  32'hCAFEF00D, 4'hF, 1'b0, 32'h0,         1'b0};
        vecs[13] = '{1'b0, BASE + 32'hFFC,  32'h0,        4'h0, 1'b1, 32'hCAFEF00D,  1'b0};
        vecs[14] = '{1'b0, BASE + 32'h8,    32'h0,        4'h0, 1'b1, 32'hDEADBEEF,  1'b0};
        vecs[15] = '{1'b0, BASE,            32'h0,        4'h0, 1'b1, 32'hAA223344,  1'b0};

        reset         = 1'b0;
        av_address    = 32'h0;
        av_read       = 1'b0;
        av_write      = 1'b0;
        av_writedata  = 32'h0;
        av_byteenable = 4'h0;
        lfsr_model    = 16'hACE1;
        repeat (3) @(negedge clk);
        check("reset_waitrequest", 32'(av_waitrequest), 32'd0);
        check("reset_readdata", av_readdata, 32'd0);
        check("reset_err_oob", 32'(err_oob), 32'd0);
        check("reset_err_proto", 32'(err_proto), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            ew = exp_window();
            xfer(vecs[i].is_write, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                 waits, rdata, oob_pulse, oob_after);
            check($sformatf("vec%0d_window", i), 32'(waits), 32'(ew));
            if (vecs[i].check_rd) check($sformatf("vec%0d_readdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_err_oob", i), 32'(oob_pulse), 32'(vecs[i].exp_oob));
            check($sformatf("vec%0d_err_oob_clear", i), 32'(oob_after), 32'd0);
        end

        // Both requests in IDLE: no stall, one-cycle protocol error, no access.
        @(negedge clk);
        av_address   = BASE;
        av_writedata = 32'h0BADF00D;
        av_byteenable = 4'hF;
        av_read      = 1'b1;
        av_write     = 1'b1;
        #1;
        check("proto_waitrequest", 32'(av_waitrequest), 32'd0);
        @(negedge clk);
        check("proto_err_proto", 32'(err_proto), 32'd1);
        av_read  = 1'b0;
        av_write = 1'b0;
        @(negedge clk);
        check("proto_err_proto_clear", 32'(err_proto), 32'd0);
        ew = exp_window();
        xfer(1'b0, BASE, 32'h0, 4'h0, waits, rdata, oob_pulse, oob_after);
        check("proto_mem_unchanged", rdata, 32'hAA223344);
        check("proto_read_window", 32'(waits), 32'(ew));

        // Master drops the read while in WAIT: back to IDLE, no error.
        @(negedge clk);
        av_address = BASE + 32'h8;
        av_read    = 1'b1;
        #1;
        check("abort_wait_idle", 32'(av_waitrequest), 32'd1);
        @(negedge clk);
        av_read = 1'b0;
        #1;
        check("abort_wait_held", 32'(av_waitrequest), 32'd1);
        @(negedge clk);
        check("abort_idle_waitrequest", 32'(av_waitrequest), 32'd0);
        check("abort_err_oob", 32'(err_oob), 32'd0);
        check("abort_err_proto", 32'(err_proto), 32'd0);
        @(negedge clk);
        check("abort_no_late_error", 32'(err_oob | err_proto), 32'd0);

        // Back-to-back reads with the request held across ACK.
        @(negedge clk);
        av_address = BASE;
        av_read    = 1'b1;
        ew = exp_window();
        count_window(w0, d0);
        check("b2b_window0", 32'(w0), 32'(ew));
        check("b2b_data0", d0, 32'hAA223344);
        model_advance();
        av_address = BASE + 32'h4;
        @(negedge clk);
        ew = exp_window();
        count_window(w1, d1);
        check("b2b_window1", 32'(w1), 32'(ew));
        check("b2b_data1", d1, 32'h01B203D4);
        model_advance();
        @(negedge clk);
        av_read = 1'b0;
        @(negedge clk);

        // Reset asserted mid-WAIT of a write: transaction dropped, memory intact.
        @(negedge clk);
        av_address    = BASE + 32'h8;
        av_writedata  = 32'h0;
        av_byteenable = 4'hF;
        av_write      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lfsr_model = 16'hACE1;
        #1;
        check("rst_mid_wait_waitrequest", 32'(av_waitrequest), 32'd1);
        check("rst_mid_wait_readdata", av_readdata, 32'd0);
        av_write = 1'b0;
        #1;
        check("rst_mid_wait_follows_req", 32'(av_waitrequest), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        ew = exp_window();
        xfer(1'b0, BASE + 32'h8, 32'h0, 4'h0, waits, rdata, oob_pulse, oob_after);
        check("rst_mid_wait_mem_unchanged", rdata, 32'hDEADBEEF);
        check("rst_mid_wait_read_window", 32'(waits), 32'(ew));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
